step_pulse_gen: RTL
===================

# step_pulse_gen

Move-command front end for the 4-phase stepper driver: it turns a single move command into a STEP/DIR/EN pulse train. Each command carries a step count, a direction and a step period. The block's PWM, DIR and EN outputs connect directly to the PWM/DIR/EN inputs of the stepper phase sequencer, one pulse per step. The block sits between the sensor/decision logic (QR, geomagnetic and GPS paths) and the motor driver, and reports completion back to the decision logic.

## Interface
- CNT_W, 16, width of step count and steps_left
- PER_W, 16, width of step period (clk cycles)
- MIN_PER, 4, minimum legal period; smaller cmd_period is clamped to this value
- SETUP_CYC, 8, cycles from EN/DIR assertion to the first PWM rising edge (driver setup time)
- RAMP_ADD, 64, extra period on the first pulse (STEP_RAMP_EN only)
- RAMP_DEC, 4, period decrement per pulse (STEP_RAMP_EN only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  move command present
- cmd_ready  out  1  high when a command can be accepted (IDLE only)
- cmd_steps  in  CNT_W  number of steps
- cmd_dir  in  1  direction for the move
- cmd_period  in  PER_W  cycles per step
- abort  in  1  stop the move at the next safe point
- PWM  out  1  step pulse to the motor driver
- DIR  out  1  direction to the motor driver
- EN  out  1  driver enable
- busy  out  1  move in progress (any state except IDLE)
- done  out  1  one-cycle pulse at the end of a move
- steps_left  out  CNT_W  remaining steps, counting the step now being issued

## Operation
- States are IDLE, SETUP, PULSE_HI, PULSE_LO and DONE.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, latch steps, dir and period_eff = max(cmd_period, MIN_PER), then go to SETUP.
  - If cmd_steps==0, go straight to DONE. EN is not asserted and no pulse is issued.
- **SETUP**
  - EN=1; DIR=latched dir.
  - Count SETUP_CYC cycles, then go to PULSE_HI.
- **PULSE_HI**
  - PWM=1 for hi = period_eff>>1 cycles, then go to PULSE_LO.
- **PULSE_LO**
  - PWM=0 for period_eff-hi cycles.
  - At the end: decrement steps_left; if the result is 0 go to DONE, otherwise go to PULSE_HI.
- **DONE**
  - done=1 and EN=0 for one cycle, then go to IDLE.
- **abort** (sampled every cycle):
  - In SETUP or PULSE_LO: go to DONE on the next edge.
  - In PULSE_HI: finish the full high phase (no runt pulse), then go to DONE.
  - In IDLE or DONE: no effect.
- DIR keeps its last value after a move ends. It changes only when a new command is accepted.
- A command presented while busy is ignored, because cmd_ready=0. It is not queued.
- All internal counters are unsigned. The period counter reloads on each phase entry and never wraps.

## Timing
- Reset values: PWM=0, DIR=0, EN=0, busy=0, done=0, steps_left=0, state IDLE (so cmd_ready=1).
- Reset in the middle of a move drops PWM and EN immediately (asynchronous) and discards the command.
- Command accepted on edge T: busy=1 and EN=1 from T+1.
- First PWM rise at T+1+SETUP_CYC.
- Each step lasts exactly period_eff cycles, rise to rise.
- Final low phase ends at edge E: done=1 during cycle E..E+1, and EN=0 from E.
- busy falls and cmd_ready rises one cycle after done. The earliest next accept is E+1.
- cmd_steps==0: done pulses one cycle after accept. EN stays 0 and busy is high for that one cycle only.
- steps_left is registered and updates at the end of each PULSE_LO.
- Outputs are all registered; there are no combinational paths from inputs to PWM, DIR or EN.

## Configuration
- STEP_RAMP_EN defined:
  - The first pulse period is period_eff+RAMP_ADD.
  - Each following pulse period is reduced by RAMP_DEC, floored at period_eff.
  - The addition saturates at 2^PER_W-1.
  - abort and steps semantics are unchanged.
- STEP_RAMP_EN undefined:
  - Every pulse uses period_eff.
  - RAMP_ADD and RAMP_DEC are unused, and no ramp logic is synthesized.

## Test plan
- Reset with rst_n=0 while PWM=1 mid-move -> PWM, EN, busy drop at once; after release cmd_ready=1 and steps_left=0.
- Defaults, no ramp; steps=3, period=10, dir=1 accepted at T -> EN=1 at T+1; PWM rises at T+9, T+19, T+29, each high 5 cycles; done one cycle at T+39; DIR stays 1 afterward.
- period=1 -> clamped to 4: PWM high 2, low 2 per step.
- steps=0 -> done pulses at T+1, PWM never toggles, EN stays 0.
- steps=100, period=10, abort pulsed during the 2nd high phase -> that pulse completes its 5 high cycles, then done; exactly 2 PWM pulses in total; steps_left=99.
- STEP_RAMP_EN, steps=20, period=10 -> pulse periods 74, 70, 66 ... reaching 10 from the 17th pulse onward; 20 pulses in total.

Source files
------------

// File: rtl/step_pulse_gen_if.sv
// step_pulse_gen_if: move-command handshake between decision logic (master) and step_pulse_gen (slave).
interface step_pulse_gen_if #(
   parameter int CNT_W = 16,
   parameter int PER_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_steps;
   logic [PER_W-1:0] cmd_period;
   modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period, input cmd_ready);
   modport slave (input cmd_valid, cmd_steps, cmd_dir, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns one move command into a STEP(PWM)/DIR/EN pulse train for the stepper sequencer.
// Define STEP_RAMP_EN to start each move slow and shorten the period pulse by pulse.
module step_pulse_gen #(
   parameter int CNT_W     = 16,
   parameter int PER_W     = 16,
   parameter int MIN_PER   = 4,
   parameter int SETUP_CYC = 8,
   parameter int RAMP_ADD  = 64,
   parameter int RAMP_DEC  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   step_pulse_gen_if.slave  cmd,
   input  logic             abort,
   output logic             PWM,
   output logic             DIR,
   output logic             EN,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left
);
   typedef enum logic [2:0] {IDLE, SETUP, PULSE_HI, PULSE_LO, DONE} state_t;
   state_t           state_q, state_d;
   logic [PER_W-1:0] per_q, per_d, cnt_q, cnt_d, per, per_nx, per_eff;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic             dir_q, dir_d, pwm_q, en_q, abort_q, abort_d, accept, step_end;
   assign per_eff  = cmd.cmd_period < PER_W'(MIN_PER) ? PER_W'(MIN_PER) : cmd.cmd_period;
   assign accept   = state_q == IDLE && cmd.cmd_valid;
   assign step_end = state_q == PULSE_LO && !abort && cnt_q == '0;
`ifdef STEP_RAMP_EN
   logic [PER_W-1:0] cur_q, cur_d;
   logic [PER_W:0]   ramp_sum;
   assign ramp_sum = {1'b0, per_eff} + (PER_W+1)'(RAMP_ADD);
   assign per      = cur_q;
   // cur_q never drops below per_q, so the difference cannot underflow
   assign per_nx   = (cur_q - per_q > PER_W'(RAMP_DEC)) ? cur_q - PER_W'(RAMP_DEC) : per_q;
   assign cur_d    = accept ? (ramp_sum[PER_W] ? '1 : ramp_sum[PER_W-1:0]) : step_end ? per_nx : cur_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cur_q <= '0;
      else        cur_q <= cur_d;
`else
   assign per    = per_q;
   assign per_nx = per_q;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - PER_W'(cnt_q != '0);
      per_d   = per_q;
      steps_d = steps_q;
      dir_d   = dir_q;
      abort_d = abort_q;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (cmd.cmd_valid) begin
               per_d   = per_eff;
               steps_d = cmd.cmd_steps;
               dir_d   = cmd.cmd_dir;
               cnt_d   = PER_W'(SETUP_CYC - 1);
               state_d = cmd.cmd_steps == '0 ? DONE : SETUP;
            end
         end
         SETUP:
            if (abort) state_d = DONE;
            else if (cnt_q == '0) begin
               state_d = PULSE_HI;
               cnt_d   = (per >> 1) - 1'b1;
            end
         PULSE_HI: begin
            // an abort seen mid-pulse is held so the high phase is never cut short
            abort_d = abort_q | abort;
            if (cnt_q == '0) begin
               state_d = (abort_q | abort) ? DONE : PULSE_LO;
               cnt_d   = per - (per >> 1) - 1'b1;
            end
         end
         PULSE_LO:
            if (abort) state_d = DONE;
            else if (step_end) begin
               steps_d = steps_q - 1'b1;
               state_d = steps_q == CNT_W'(1) ? DONE : PULSE_HI;
               cnt_d   = (per_nx >> 1) - 1'b1;
            end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         steps_q <= '0;
         dir_q   <= 1'b0;
         abort_q <= 1'b0;
         pwm_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         steps_q <= steps_d;
         dir_q   <= dir_d;
         abort_q <= abort_d;
         pwm_q   <= state_d == PULSE_HI;
         en_q    <= state_d inside {SETUP, PULSE_HI, PULSE_LO};
      end
   assign PWM           = pwm_q;
   assign DIR           = dir_q;
   assign EN            = en_q;
   assign busy          = state_q != IDLE;
   assign done          = state_q == DONE;
   assign cmd.cmd_ready = state_q == IDLE;
   assign steps_left    = steps_q;
endmodule
